pe_array_feeder: RTL and testbench
==================================

// Module: pe_array_feeder
// PURPOSE
//   Sequencer that drives the 72-PE convolution array from on-chip SRAM.
//   Loads one 3x3 filter plus bias, then streams ifmap rows as a sliding
//   3-row window on ifmapIn1/2/3: one new window per cycle, each 8 pixels wide.
//   Sits between the ifmap/weight SRAMs and PE_array. A start/busy/done
//   handshake with the top-level controller brackets each tile.
// PARAMETERS
//   ADDR_W  10  ifmap and weight SRAM address width
//   IMG_H   10  ifmap rows per tile; must be >= 3, elaborate-time $error otherwise
//   ROW_W   4   width of feed_row; must satisfy 2**ROW_W >= IMG_H
// PORTS
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   start        in   1       one-cycle pulse; sampled only in IDLE
//   ifmap_base   in   ADDR_W  address of ifmap row 0, latched on start
//   w_base       in   ADDR_W  address of the {bias,filter} word, latched on start
//   hold         in   1       back-pressure; 1 = issue no new row reads
//   w_ren        out  1       weight SRAM read enable
//   w_addr       out  ADDR_W  weight SRAM address
//   w_rdata      in   88      {bias[15:0], filter[71:0]}, valid 1 cycle after w_ren
//   ifmap_ren    out  1       ifmap SRAM read enable
//   ifmap_addr   out  ADDR_W  ifmap SRAM address, ifmap_base + row index
//   ifmap_rdata  in   64      one 8-pixel row, valid 1 cycle after ifmap_ren
//   ifmapIn1     out  64      window row r (oldest)
//   ifmapIn2     out  64      window row r+1
//   ifmapIn3     out  64      window row r+2 (newest)
//   filter       out  72      filter taps, held constant through the tile
//   bias         out  16      bias, held constant through the tile
//   feed_valid   out  1       current ifmapIn1..3 window is new this cycle
//   feed_row     out  ROW_W   index r of the window on feed_valid
//   busy         out  1       tile in progress
//   done         out  1       one-cycle pulse after the last window
// BEHAVIOUR
//   - Reset: all registered outputs and window regs 0; FSM enters IDLE. Reset mid-tile
//     aborts the tile with no done pulse.
//   - FSM states: IDLE -> LOADW (1 cycle) -> STREAM -> FLUSH -> DONE (1 cycle) -> IDLE.
//   - w_ren and ifmap_ren are decoded combinationally from state and counters.
//     rdata is captured at the edge that ends the cycle after ren.
//   - Window shift on every ifmap capture: R1<=R2, R2<=R3, R3<=ifmap_rdata.
//     ifmapIn1..3 = R1..R3 (registered).
//   - feed_valid is high in the cycle after the 3rd and every later capture.
//     feed_row increments per window, starting at 0.
//   - hold=1 blocks issuing a new read (and the zero insert when ZERO_PAD_EN is defined).
//     An in-flight read is still captured. Windows and filter are otherwise frozen.
//   - Start in IDLE: latch bases, enter LOADW, busy=1 from the next cycle.
//     start while busy is ignored.
//   - Timeline, no hold, start sampled at end of cycle 0:
//     - cycle 1: w_ren=1.
//     - cycle 2+k: ifmap_ren for row k, k=0..IMG_H-1.
//     - from cycle 3: filter and bias are valid.
//     - cycles 6 .. IMG_H+3: feed_valid high.
//     - cycle IMG_H+4: done=1 and busy=1.
//     - cycle IMG_H+5: busy=0.
//   - FLUSH waits for the final capture, then goes to DONE. Total windows per tile = IMG_H-2.
//   - Address arithmetic is modulo 2**ADDR_W; wrap-around is allowed.
// CONFIGURATION
//   ZERO_PAD_EN: vertical padding of 1.
//   - Undefined: IMG_H-2 windows per tile, as above.
//   - Defined: a zero row is shifted in at the cycle-2 capture edge, with no read.
//     - An extra zero row is shifted in during FLUSH, after row IMG_H-1 is captured.
//     - IMG_H windows per tile, first window {0,row0,row1}, last {row(H-2),row(H-1),0}.
//     - feed_valid in cycles 5 .. IMG_H+4; done in cycle IMG_H+5.
// TESTING
//   1. Reset: assert rst mid-stream -> all outputs 0 at once, IDLE, no done pulse.
//   2. IMG_H=10, row k = {8{8'(k+1)}}, w_rdata = {16'h0005, 72'h09..01}:
//      - filter and bias are valid from cycle 3.
//      - feed_valid in cycles 6..13, window r = rows r..r+2, feed_row 0..7.
//      - done in cycle 14.
//   3. hold=1 during cycles 5-7:
//      - reads for rows 3-5 are delayed 3 cycles.
//      - still exactly 8 windows in order, no duplicates or skips; done in cycle 17.
//   4. start pulsed in cycles 4 and 14:
//      - both are ignored.
//      - a start in cycle 16 begins a new tile with the new bases.
//   5. ifmap_base=10'h3FE:
//      - addresses run 3FE, 3FF, 000, ... 007.
//      - windows stay correct.
//   6. ZERO_PAD_EN defined, IMG_H=10:
//      - 10 windows, first {0,row0,row1}, last {row8,row9,0}.
//      - done in cycle 15.

Source files
------------

// File: rtl/pe_array_feeder_if.sv
// rtl/pe_array_feeder_if.sv - handshake, SRAM and PE-feed bundle for pe_array_feeder
// Purpose: groups every non-clock/reset signal of the feeder.
// Modports:
//   slave  - the feeder: takes start/bases/hold and SRAM read data,
//            drives SRAM read requests, the 3-row window, filter/bias and status.
//   master - controller, SRAMs and PE array side (directions mirrored).
interface pe_array_feeder_if #(
  parameter int ADDR_W = 10,
  parameter int ROW_W  = 4
);
  logic              start;
  logic [ADDR_W-1:0] ifmap_base;
  logic [ADDR_W-1:0] w_base;
  logic              hold;
  logic              w_ren;
  logic [ADDR_W-1:0] w_addr;
  logic [87:0]       w_rdata;
  logic              ifmap_ren;
  logic [ADDR_W-1:0] ifmap_addr;
  logic [63:0]       ifmap_rdata;
  logic [63:0]       ifmapIn1;
  logic [63:0]       ifmapIn2;
  logic [63:0]       ifmapIn3;
  logic [71:0]       filter;
  logic [15:0]       bias;
  logic              feed_valid;
  logic [ROW_W-1:0]  feed_row;
  logic              busy;
  logic              done;

  modport slave (
    input  start, ifmap_base, w_base, hold, w_rdata, ifmap_rdata,
    output w_ren, w_addr, ifmap_ren, ifmap_addr, ifmapIn1, ifmapIn2, ifmapIn3,
           filter, bias, feed_valid, feed_row, busy, done
  );

  modport master (
    output start, ifmap_base, w_base, hold, w_rdata, ifmap_rdata,
    input  w_ren, w_addr, ifmap_ren, ifmap_addr, ifmapIn1, ifmapIn2, ifmapIn3,
           filter, bias, feed_valid, feed_row, busy, done
  );
endinterface

// File: rtl/pe_array_feeder.sv
// rtl/pe_array_feeder.sv - sliding 3-row window sequencer feeding the 72-PE conv array
// Purpose: on start, reads one {bias,filter} word, then IMG_H ifmap rows, and
//   presents a new 3-row window (ifmapIn1 oldest .. ifmapIn3 newest) per capture.
// Ports: clk, rst (async, active-high); bus (pe_array_feeder_if.slave):
//   start/ifmap_base/w_base/hold in; w_ren/w_addr + w_rdata weight SRAM;
//   ifmap_ren/ifmap_addr + ifmap_rdata row SRAM; ifmapIn1..3, filter, bias,
//   feed_valid, feed_row, busy, done out.
// Option: define ZERO_PAD_EN for vertical zero padding of one row top and bottom.
module pe_array_feeder #(
  parameter int ADDR_W = 10,
  parameter int IMG_H  = 10,
  parameter int ROW_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  pe_array_feeder_if.slave bus
);

  if (IMG_H < 3) begin : g_bad_img_h
    $error("pe_array_feeder: IMG_H must be >= 3");
  end
  if ((2 ** ROW_W) < IMG_H) begin : g_bad_row_w
    $error("pe_array_feeder: ROW_W too narrow for IMG_H");
  end

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  typedef enum logic [2:0] {IDLE, LOADW, STREAM, FLUSH, DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ifmap_base_q, w_base_q;
  logic [ROW_W-1:0]  rd_idx, win_idx, row_q;
  logic              w_pend, rd_pend;
  logic [1:0]        fill;
  logic [63:0]       r1, r2, r3;
  logic [71:0]       filt_q;
  logic [15:0]       bias_q;
  logic              fv_q;
  logic              w_ren, ifmap_ren, zero_ins, tail_ok, shift;

`ifdef ZERO_PAD_EN
  logic              head_done, tail_done;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; FLUSH leaves only once nothing is in flight and any
  // trailing pad row has been shifted in.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = LOADW;
      LOADW:   state_nx = STREAM;
      STREAM:  if (ifmap_ren && rd_idx == LAST_ROW) state_nx = FLUSH;
      FLUSH:   if (!rd_pend && tail_ok) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_ren     = (state == LOADW);
    ifmap_ren = (state == STREAM) && !bus.hold;
    zero_ins  = 1'b0;
    tail_ok   = 1'b1;
`ifdef ZERO_PAD_EN
    // Head pad coincides with the row-0 read; tail pad follows the last capture.
    zero_ins  = !bus.hold && (((state == STREAM) && !head_done) ||
                              ((state == FLUSH) && !rd_pend && !tail_done));
    tail_ok   = tail_done;
`endif
  end

  // A window shift happens on every captured row and on every pad insert;
  // the two never coincide.
  assign shift = rd_pend || zero_ins;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifmap_base_q <= '0;
      w_base_q     <= '0;
      rd_idx       <= '0;
      win_idx      <= '0;
      row_q        <= '0;
      w_pend       <= 1'b0;
      rd_pend      <= 1'b0;
      fill         <= '0;
      r1           <= '0;
      r2           <= '0;
      r3           <= '0;
      filt_q       <= '0;
      bias_q       <= '0;
      fv_q         <= 1'b0;
    end else begin
      w_pend  <= w_ren;
      rd_pend <= ifmap_ren;
      if (state == IDLE) begin
        rd_idx  <= '0;
        win_idx <= '0;
        fill    <= '0;
        if (bus.start) begin
          ifmap_base_q <= bus.ifmap_base;
          w_base_q     <= bus.w_base;
        end
      end
      if (ifmap_ren) rd_idx <= rd_idx + 1'b1;
      if (w_pend) {bias_q, filt_q} <= bus.w_rdata;
      if (shift) begin
        r1 <= r2;
        r2 <= r3;
        r3 <= rd_pend ? bus.ifmap_rdata : 64'd0;
        if (fill != 2'd2) fill <= fill + 2'd1;
      end
      // The third and every later shift completes a window.
      fv_q <= shift && (fill == 2'd2);
      if (shift && fill == 2'd2) begin
        row_q   <= win_idx;
        win_idx <= win_idx + 1'b1;
      end
    end
  end

`ifdef ZERO_PAD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_done <= 1'b0;
      tail_done <= 1'b0;
    end else if (state == IDLE) begin
      head_done <= 1'b0;
      tail_done <= 1'b0;
    end else if (zero_ins) begin
      if (state == STREAM) head_done <= 1'b1;
      if (state == FLUSH)  tail_done <= 1'b1;
    end
  end
`endif

  assign bus.w_ren      = w_ren;
  assign bus.w_addr     = w_base_q;
  assign bus.ifmap_ren  = ifmap_ren;
  assign bus.ifmap_addr = ifmap_base_q + ADDR_W'(rd_idx);
  assign bus.ifmapIn1   = r1;
  assign bus.ifmapIn2   = r2;
  assign bus.ifmapIn3   = r3;
  assign bus.filter     = filt_q;
  assign bus.bias       = bias_q;
  assign bus.feed_valid = fv_q;
  assign bus.feed_row   = row_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_pe_array_feeder.sv
// tb/tb_pe_array_feeder.sv - scoreboard bench for pe_array_feeder
module tb_pe_array_feeder;
  localparam int IMG_H = 10;

  typedef struct {
    int          cyc;
    logic [63:0] a, b, c;
    logic [3:0]  row;
    logic [87:0] wt;
  } win_t;
  typedef struct {
    int         cyc;
    logic [9:0] addr;
  } acc_t;

  logic clk, rst;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  int   t0 = 0, hlo = 1000, hhi = -1, cur_seed = 0;
  logic [9:0] cur_base = '0;
  win_t win_q[$];
  acc_t a_q[$], w_q[$];
  int   done_q[$];
  win_t w;
  acc_t ac;
  int   dc;

  pe_array_feeder_if #(.ADDR_W(10), .ROW_W(4)) bus ();
  pe_array_feeder #(.ADDR_W(10), .IMG_H(IMG_H), .ROW_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] rowpat(input int k, input int s);
    logic [7:0] b;
    b = 8'(k + s);
    return {8{b}};
  endfunction

  function automatic logic [87:0] wword(input logic [9:0] a);
    return {16'h0005 + 16'(a), 72'h090807060504030201 + 72'(a)};
  endfunction

  // SRAM models: one-cycle read latency
  always @(posedge clk) begin
    if (bus.w_ren) bus.w_rdata <= wword(bus.w_addr);
    if (bus.ifmap_ren) bus.ifmap_rdata <= rowpat(int'(10'(bus.ifmap_addr - cur_base)), cur_seed);
  end

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Expected schedule: reads issue in every non-held cycle from cycle 2,
  // each row shifts in one cycle later; windows appear the cycle after the
  // 3rd and later shifts; done two cycles after the last shift.
  task automatic plan(input logic [9:0] ib, input logic [9:0] wb, input int seed);
    int c, k;
    logic [63:0] sd[$];
    int sc[$];
    w_q.push_back('{t0 + 1, wb});
    c = 2;
    k = 0;
    while (k < IMG_H) begin
      if (!(c >= hlo && c <= hhi)) begin
`ifdef ZERO_PAD_EN
        if (k == 0) begin sd.push_back(64'd0); sc.push_back(c); end
`endif
        a_q.push_back('{t0 + c, ib + 10'(k)});
        sd.push_back(rowpat(k, seed));
        sc.push_back(c + 1);
        k++;
      end
      c++;
    end
`ifdef ZERO_PAD_EN
    c = c + 1;
    while (c >= hlo && c <= hhi) c++;
    sd.push_back(64'd0);
    sc.push_back(c);
`endif
    for (int i = 2; i < sd.size(); i++)
      win_q.push_back('{t0 + sc[i] + 1, sd[i-2], sd[i-1], sd[i], 4'(i - 2), wword(wb)});
    done_q.push_back(t0 + sc[sc.size()-1] + 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.hold = (cyc - t0 >= hlo) && (cyc - t0 <= hhi);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic start_tile(input logic [9:0] ib, input logic [9:0] wb, input int seed,
                            input int lo, input int hi);
    tick();
    t0 = cyc; hlo = lo; hhi = hi;
    bus.hold = 1'b0;
    bus.start = 1'b1;
    bus.ifmap_base = ib;
    bus.w_base = wb;
    cur_base = ib;
    cur_seed = seed;
    plan(ib, wb, seed);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_start(input logic [9:0] ib, input logic [9:0] wb);
    tick();
    bus.start = 1'b1; bus.ifmap_base = ib; bus.w_base = wb;
    tick();
    bus.start = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.feed_valid) begin
        if (win_q.size() == 0) chk("win_unexpected", 256'(1), 256'(0));
        else begin
          w = win_q.pop_front();
          chk("win_cycle", 256'(cyc), 256'(w.cyc));
          chk("win_rows", 256'({bus.ifmapIn1, bus.ifmapIn2, bus.ifmapIn3}), 256'({w.a, w.b, w.c}));
          chk("feed_row", 256'(bus.feed_row), 256'(w.row));
          chk("bias_filter", 256'({bus.bias, bus.filter}), 256'(w.wt));
        end
      end
      if (bus.ifmap_ren) begin
        if (a_q.size() == 0) chk("ifmap_ren_unexpected", 256'(1), 256'(0));
        else begin
          ac = a_q.pop_front();
          chk("ifmap_ren_cycle", 256'(cyc), 256'(ac.cyc));
          chk("ifmap_addr", 256'(bus.ifmap_addr), 256'(ac.addr));
        end
      end
      if (bus.w_ren) begin
        if (w_q.size() == 0) chk("w_ren_unexpected", 256'(1), 256'(0));
        else begin
          ac = w_q.pop_front();
          chk("w_ren_cycle", 256'(cyc), 256'(ac.cyc));
          chk("w_addr", 256'(bus.w_addr), 256'(ac.addr));
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) chk("done_unexpected", 256'(1), 256'(0));
        else begin
          dc = done_q.pop_front();
          chk("done_cycle", 256'(cyc), 256'(dc));
          chk("busy_at_done", 256'(bus.busy), 256'(1));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.ifmap_base = '0; bus.w_base = '0; bus.hold = 1'b0;
    bus.w_rdata = '0; bus.ifmap_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 256'({bus.busy, bus.done, bus.feed_valid, bus.w_ren, bus.ifmap_ren}), 256'(0));
    chk("reset_win", 256'({bus.ifmapIn1, bus.ifmapIn2, bus.ifmapIn3}), 256'(0));
    chk("reset_wt", 256'({bus.bias, bus.filter, bus.feed_row}), 256'(0));
    rst = 1'b0;
    tick();

    // Basic tile
    chk("idle_busy", 256'(bus.busy), 256'(0));
    start_tile(10'h000, 10'h000, 1, 1000, -1);
    chk("busy_c1", 256'(bus.busy), 256'(1));
    tick();
    chk("filter_c2", 256'({bus.bias, bus.filter}), 256'(0));
    tick();
    chk("filter_c3", 256'({bus.bias, bus.filter}), 256'({16'h0005, 72'h090807060504030201}));
`ifdef ZERO_PAD_EN
    run(13);
`else
    run(12);
`endif
    chk("busy_after_done", 256'(bus.busy), 256'(0));

    // Hold during cycles 5..7
    start_tile(10'h040, 10'h003, 8'h11, 5, 7);
    run(20);

    // Starts while busy are ignored; start at cycle 16 begins the next tile
    start_tile(10'h100, 10'h007, 8'h31, 1000, -1);
    run(2);
    pulse_start(10'h200, 10'h002);
    run(8);
    pulse_start(10'h300, 10'h004);
    start_tile(10'h180, 10'h009, 8'h51, 1000, -1);
    run(18);

    // Address wrap-around
    start_tile(10'h3FE, 10'h005, 8'h71, 1000, -1);
    run(18);

    // Reset mid-stream aborts without done
    start_tile(10'h020, 10'h001, 8'h61, 1000, -1);
    run(7);
    win_q.delete(); a_q.delete(); w_q.delete(); done_q.delete();
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", 256'({bus.busy, bus.done, bus.feed_valid, bus.w_ren, bus.ifmap_ren}), 256'(0));
    chk("midrst_win", 256'({bus.ifmapIn1, bus.ifmapIn2, bus.ifmapIn3}), 256'(0));
    chk("midrst_wt", 256'({bus.bias, bus.filter, bus.feed_row}), 256'(0));
    tick();
    tick();
    rst = 1'b0;
    run(20);
    chk("after_rst_busy", 256'(bus.busy), 256'(0));

    chk("leftover_expectations", 256'(win_q.size() + a_q.size() + w_q.size() + done_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
